ahb_slave: RTL and testbench

//  AHB-Lite slave bridging single AHB transfers onto a simple valid/ready memory port.

---
 rtl/ahb_pkg.sv | 22 ++
 rtl/ahb_slave.sv | 131 +++++++++++++
 tb/tb_ahb_slave.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared definitions for the AHB-Lite to memory-port bridge.
// Holds the HTRANS encodings, the OKAY response code and the FSM state type
// used by ahb_slave.
package ahb_pkg;

    // HTRANS encodings. Only IDLE is distinguished by the bridge; every other
    // value is treated as the start of a transfer.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY = 1'b0;

    // WRITE and READ both mean "a data phase is in progress" with that direction.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10
    } state_e;

endpackage

// File: rtl/ahb_slave.sv
// ahb_slave: AHB-Lite slave that turns single AHB transfers into accesses on a
// simple valid/ready memory port.
//
// Ports
//   i_clk_ahb, i_rstn_ahb      HCLK and synchronous active-low reset
//   i_hselx, i_hready,         AHB address-phase inputs (select, bus ready,
//   i_htrans, i_hwrite,        transfer type, direction, address)
//   i_haddr
//   i_hsize, i_hburst,         accepted but unused (word, single transfers only)
//   i_hprot, i_hmastlock
//   i_hwdata                   AHB write data (data phase)
//   i_ready                    memory ready; low stalls the current data phase
//   i_rd_valid, i_rd_data      memory read return, same cycle as i_ready
//   o_hreadyout, o_hresp,      AHB slave response
//   o_hrdata
//   o_valid, o_rd0_wr1,        memory request: valid, direction (1 = write),
//   o_wr_data, o_addr          write data and address
//
// Memory port handshake: a request is presented while o_valid=1 and is
// consumed on the rising edge where i_ready=1. While i_ready=0 the request
// (o_addr, o_rd0_wr1, and the master-held o_wr_data) stays unchanged. Read
// data must arrive with i_rd_valid=1 in the same cycle as i_ready=1.
module ahb_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_hselx,
    input  logic                  i_hready,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [2:0]            i_hsize,
    input  logic [2:0]            i_hburst,
    input  logic [3:0]            i_hprot,
    input  logic                  i_hmastlock,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_ready,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_valid,
    output logic                  o_rd0_wr1,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  start;

    // Sideband attributes are not needed for word-only single transfers.
    logic unused_inputs;
    assign unused_inputs = ^{i_hsize, i_hburst, i_hprot, i_hmastlock};

    assign start = i_hselx & i_hready & (i_htrans != HTRANS_IDLE);

    // Next-state logic. A new address phase is only taken when no data phase
    // is outstanding, or the outstanding one finishes at this edge; that gives
    // zero-wait back-to-back pipelining while a stall freezes everything.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = i_haddr;
                    write_d = i_hwrite;
                    state_d = i_hwrite ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                if (i_ready) begin
                    if (start) begin
                        addr_d  = i_haddr;
                        write_d = i_hwrite;
                        state_d = i_hwrite ? ST_WRITE : ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_ahb) begin
        if (!i_rstn_ahb) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    // Outputs. Data paths are pure pass-through so neither direction adds a
    // cycle of latency.
    always_comb begin
        o_valid     = 1'b0;
        o_rd0_wr1   = 1'b0;
        o_hreadyout = 1'b1;
        o_hrdata    = '0;
        if (state_q != ST_IDLE) begin
            o_valid     = 1'b1;
            o_rd0_wr1   = write_q;
            o_hreadyout = i_ready;
        end
        // A read that completes without i_rd_valid returns zero rather than
        // stalling; the memory is required to pair the two signals.
        if ((state_q == ST_READ) && i_rd_valid) begin
            o_hrdata = i_rd_data;
        end
    end

    assign o_addr    = addr_q;
    assign o_wr_data = i_hwdata;
    assign o_hresp   = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_slave.sv
// tb_ahb_slave: directed self-checking bench for ahb_slave.
// A transaction-level model tracks which transfer owns the data phase and
// predicts every output each cycle; a scoreboard queue holds the hand-written
// list of transfers that must complete, in order, with their address/data.
module tb_ahb_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int EW = 1 + AW + DW;   // {is_write, addr, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic          hselx = 1'b0;
    logic          hready = 1'b1;
    logic [1:0]    htrans = 2'b00;
    logic          hwrite = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [2:0]    hsize = 3'b010;
    logic [2:0]    hburst = 3'b000;
    logic [3:0]    hprot = 4'b0011;
    logic          hmastlock = 1'b0;
    logic [DW-1:0] hwdata = '0;
    logic          mready = 1'b1;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          mvalid;
    logic          rd0_wr1;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] maddr;

    ahb_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk_ahb   (clk),
        .i_rstn_ahb  (rstn),
        .i_hselx     (hselx),
        .i_hready    (hready),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_haddr     (haddr),
        .i_hsize     (hsize),
        .i_hburst    (hburst),
        .i_hprot     (hprot),
        .i_hmastlock (hmastlock),
        .i_hwdata    (hwdata),
        .i_ready     (mready),
        .i_rd_valid  (rd_valid),
        .i_rd_data   (rd_data),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .o_valid     (mvalid),
        .o_rd0_wr1   (rd0_wr1),
        .o_wr_data   (wr_data),
        .o_addr      (maddr)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic checking = 1'b0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_busy/m_write/m_addr describe the transfer that currently owns the data
    // phase. A transfer enters when its address phase is accepted (slave
    // selected, bus ready, non-IDLE) and the previous one is absent or done.
    logic          m_busy = 1'b0;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_busy  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
        end else if (!m_busy || mready) begin
            if (hselx && hready && htrans != 2'b00) begin
                m_busy  <= 1'b1;
                m_write <= hwrite;
                m_addr  <= haddr;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            chk("valid",     EW'(mvalid),    EW'(m_busy));
            chk("rd0_wr1",   EW'(rd0_wr1),   EW'(m_busy && m_write));
            chk("addr",      EW'(maddr),     EW'(m_addr));
            chk("hreadyout", EW'(hreadyout), EW'(m_busy ? mready : 1'b1));
            chk("hresp",     EW'(hresp),     EW'(1'b0));
            chk("wr_data",   EW'(wr_data),   EW'(hwdata));
            chk("hrdata",    EW'(hrdata),    EW'((m_busy && !m_write && rd_valid) ? rd_data : '0));
            // Scoreboard: a transfer completes on an edge where it owns the
            // data phase and the memory is ready.
            if (rstn && m_busy && mready) begin
                chk("xfer_expected", EW'(exp_q.size() != 0), EW'(1'b1));
                if (exp_q.size() != 0) begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("xfer_dir",  EW'(rd0_wr1), EW'(e[EW-1]));
                    chk("xfer_addr", EW'(maddr),   EW'(e[DW +: AW]));
                    chk("xfer_data", EW'(e[EW-1] ? wr_data : hrdata), EW'(e[DW-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One bus cycle: present the next address phase and the current data
    // phase just after the rising edge, then return just after the falling
    // edge so the caller can check outputs for that cycle. The mux's HREADY
    // follows this slave's ready for the data phase in flight.
    task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic rdy, input logic rdv, input logic [DW-1:0] rdd);
        @(posedge clk);
        #1;
        hselx    = sel;
        htrans   = trans;
        hwrite   = wr;
        haddr    = a;
        hwdata   = wd;
        mready   = rdy;
        hready   = rdy;
        rd_valid = rdv;
        rd_data  = rdd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic [DW-1:0] wd, input logic rdy, input logic rdv,
                            input logic [DW-1:0] rdd);
        cyc(1'b0, 2'b00, 1'b0, '0, wd, rdy, rdv, rdd);
    endtask

    task automatic push_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({wr, a, d});
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_valid",  EW'(mvalid),    EW'(1'b0));
        chk("rst_hready", EW'(hreadyout), EW'(1'b1));
        chk("rst_addr",   EW'(maddr),     EW'(0));
        chk("rst_hrdata", EW'(hrdata),    EW'(0));
        chk("rst_hresp",  EW'(hresp),     EW'(0));

        // 1: write A, read B, write C back-to-back, zero wait
        push_xfer(1'b1, 32'hA, 32'haaaa_aaaa);
        push_xfer(1'b0, 32'hB, 32'hbbbb_bbbb);
        push_xfer(1'b1, 32'hC, 32'hcccc_cccc);
        cyc(1'b1, 2'b10, 1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t1_idle_valid", EW'(mvalid), EW'(1'b0));
        cyc(1'b1, 2'b10, 1'b0, 32'hB, 32'haaaa_aaaa, 1'b1, 1'b0, 32'h0);
        chk("t1_wa_addr",  EW'(maddr),     EW'(32'hA));
        chk("t1_wa_dir",   EW'(rd0_wr1),   EW'(1'b1));
        chk("t1_wa_data",  EW'(wr_data),   EW'(32'haaaa_aaaa));
        chk("t1_wa_ready", EW'(hreadyout), EW'(1'b1));
        cyc(1'b1, 2'b10, 1'b1, 32'hC, 32'h0, 1'b1, 1'b1, 32'hbbbb_bbbb);
        chk("t1_rb_addr",  EW'(maddr),     EW'(32'hB));
        chk("t1_rb_data",  EW'(hrdata),    EW'(32'hbbbb_bbbb));
        chk("t1_rb_ready", EW'(hreadyout), EW'(1'b1));
        idle_cyc(32'hcccc_cccc, 1'b1, 1'b0, 32'h0);
        chk("t1_wc_addr",  EW'(maddr),     EW'(32'hC));
        chk("t1_wc_data",  EW'(wr_data),   EW'(32'hcccc_cccc));
        idle_cyc(32'h0, 1'b1, 1'b0, 32'h0);
        chk("t1_end_valid", EW'(mvalid), EW'(1'b0));

        // 2: four writes with a one-cycle stall in the 0x38 data phase
        push_xfer(1'b1, 32'h38, 32'h38);
        push_xfer(1'b1, 32'h3C, 32'h3C);
        push_xfer(1'b1, 32'h30, 32'h30);
        push_xfer(1'b1, 32'h34, 32'h34);
        cyc(1'b1, 2'b10, 1'b1, 32'h38, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 2'b10, 1'b1, 32'h3C, 32'h38, 1'b0, 1'b0, 32'h0);
        chk("t2_stall_ready", EW'(hreadyout), EW'(1'b0));
        chk("t2_stall_addr",  EW'(maddr),     EW'(32'h38));
        cyc(1'b1, 2'b10, 1'b1, 32'h3C, 32'h38, 1'b1, 1'b0, 32'h0);
        chk("t2_held_addr",  EW'(maddr),     EW'(32'h38));
        chk("t2_held_data",  EW'(wr_data),   EW'(32'h38));
        chk("t2_held_ready", EW'(hreadyout), EW'(1'b1));
        cyc(1'b1, 2'b10, 1'b1, 32'h30, 32'h3C, 1'b1, 1'b0, 32'h0);
        chk("t2_3c_addr", EW'(maddr), EW'(32'h3C));
        cyc(1'b1, 2'b10, 1'b1, 32'h34, 32'h30, 1'b1, 1'b0, 32'h0);
        chk("t2_30_addr", EW'(maddr), EW'(32'h30));
        idle_cyc(32'h34, 1'b1, 1'b0, 32'h0);
        chk("t2_34_addr", EW'(maddr), EW'(32'h34));
        idle_cyc(32'h0, 1'b1, 1'b0, 32'h0);

        // 3: IDLE htrans, then deselected NONSEQ: no request
        cyc(1'b1, 2'b00, 1'b1, 32'h50, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 2'b10, 1'b1, 32'h54, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("t3_valid_a", EW'(mvalid), EW'(1'b0));
        idle_cyc(32'h0, 1'b1, 1'b0, 32'h0);
        chk("t3_valid_b", EW'(mvalid),    EW'(1'b0));
        chk("t3_ready",   EW'(hreadyout), EW'(1'b1));
        chk("t3_hresp",   EW'(hresp),     EW'(1'b0));

        // 4: read without rd_valid returns 0, then one with DEAD_BEEF
        push_xfer(1'b0, 32'h60, 32'h0);
        push_xfer(1'b0, 32'h64, 32'hDEAD_BEEF);
        cyc(1'b1, 2'b10, 1'b0, 32'h60, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 2'b10, 1'b0, 32'h64, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
        chk("t4_novalid", EW'(hrdata), EW'(32'h0));
        idle_cyc(32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("t4_valid", EW'(hrdata), EW'(32'hDEAD_BEEF));
        idle_cyc(32'h0, 1'b1, 1'b1, 32'h5555_5555);
        chk("t4_idle_hrdata", EW'(hrdata), EW'(32'h0));

        // 5: reset during a stalled write; that write never completes
        cyc(1'b1, 2'b10, 1'b1, 32'h70, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
        chk("t5_stall_valid", EW'(mvalid),    EW'(1'b1));
        chk("t5_stall_ready", EW'(hreadyout), EW'(1'b0));
        chk("t5_stall_addr",  EW'(maddr),     EW'(32'h70));
        rstn = 1'b0;
        cyc(1'b0, 2'b00, 1'b0, 32'h0, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
        chk("t5_rst_valid", EW'(mvalid),    EW'(1'b0));
        chk("t5_rst_ready", EW'(hreadyout), EW'(1'b1));
        chk("t5_rst_addr",  EW'(maddr),     EW'(32'h0));
        chk("t5_rst_dir",   EW'(rd0_wr1),   EW'(1'b0));
        rstn = 1'b1;
        idle_cyc(32'h0, 1'b1, 1'b0, 32'h0);

        // one more transfer after reset to show the bridge recovers
        push_xfer(1'b1, 32'h80, 32'h1357_9BDF);
        cyc(1'b1, 2'b11, 1'b1, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0);
        idle_cyc(32'h1357_9BDF, 1'b1, 1'b0, 32'h0);
        chk("t5_after_addr", EW'(maddr), EW'(32'h80));
        idle_cyc(32'h0, 1'b1, 1'b0, 32'h0);

        checking = 1'b0;
        chk("xfers_all_seen", EW'(exp_q.size()), EW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
